// File: rtl/sprite_pkg.sv
// Shared state encoding and ROM field widths for the sprite row scheduler.
package sprite_pkg;
  localparam int SPR_W_DEF = 9;
  localparam int SPR_H_DEF = 12;
  localparam int DIR_W = 2;
  localparam int ROW_W = 4;
  localparam int COL_W = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_FETCH = 2'd2
  } state_e;

  localparam logic [1:0] ST_IDLE  = S_IDLE;
  localparam logic [1:0] ST_SCAN  = S_SCAN;
  localparam logic [1:0] ST_FETCH = S_FETCH;
endpackage

// File: rtl/sprite_anim_timer.sv
// Frame counter that toggles the sprite animation phase
// every ANIM_FRAMES frame_start pulses.
module sprite_anim_timer
  import sprite_pkg::*;
#(
  parameter int ANIM_FRAMES = 8,
  localparam int CW = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_frame_start,
  output logic o_anim
);
  logic [CW-1:0] r_cnt;
  logic          r_anim;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt  <= '0;
      r_anim <= 1'b0;
    end else if (i_frame_start) begin
      if (r_cnt == CW'(ANIM_FRAMES - 1)) begin
        r_cnt  <= '0;
        r_anim <= ~r_anim;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_anim = r_anim;
endmodule

// File: rtl/sprite_row_scheduler.sv
// Hblank row fetcher and pixel server for NUM_SPRITES sprite slots.
// Animation phase timer is built only with SPRITE_ROW_SCHED_ANIM_EN defined.
module sprite_row_scheduler
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = 4,
  parameter int SPR_W       = SPR_W_DEF,
  parameter int SPR_H       = SPR_H_DEF,
  parameter int ANIM_FRAMES = 8,
  localparam int IDW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_line_start,
  input  logic                     i_frame_start,
  input  logic [8:0]               i_hpos,
  input  logic [8:0]               i_vpos,
  input  logic [NUM_SPRITES-1:0]   i_spr_en,
  input  logic [NUM_SPRITES*9-1:0] i_spr_x,
  input  logic [NUM_SPRITES*9-1:0] i_spr_y,
  input  logic [NUM_SPRITES*2-1:0] i_spr_dir,
  output logic [DIR_W-1:0]         o_rom_dir,
  output logic                     o_rom_anim,
  output logic [ROW_W-1:0]         o_rom_y,
  output logic [COL_W-1:0]         o_rom_x,
  input  logic                     i_rom_bit,
  output logic                     o_pix,
  output logic [IDW-1:0]           o_pix_id,
  output logic                     o_busy
);
  logic [1:0]       r_state;
  logic [8:0]       r_tgt;
  logic [IDW-1:0]   r_slot;
  logic [SPR_W-1:0] r_buf [NUM_SPRITES];
  logic [DIR_W-1:0] r_rom_dir;
  logic [ROW_W-1:0] r_rom_y;
  logic [COL_W-1:0] r_rom_x;
  logic             r_pix;
  logic [IDW-1:0]   r_pix_id;

  logic [8:0]       w_slot_y;
  logic [1:0]       w_slot_dir;
  logic [8:0]       w_off;
  logic             w_hit;
  logic             w_last;
  logic             w_col_last;
  logic [8:0]       w_d [NUM_SPRITES];
  logic             w_pix;
  logic [IDW-1:0]   w_pix_id;

  assign w_slot_y   = i_spr_y[r_slot*9 +: 9];
  assign w_slot_dir = i_spr_dir[r_slot*2 +: 2];
  assign w_off      = r_tgt - w_slot_y;
  assign w_hit      = i_spr_en[r_slot] && (w_off < 9'(SPR_H));
  assign w_last     = (r_slot == IDW'(NUM_SPRITES - 1));
  assign w_col_last = (r_rom_x == COL_W'(SPR_W - 1));
  assign o_busy     = (r_state != ST_IDLE);

  // The ROM address registers double as the fetch row/column state.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_tgt     <= '0;
      r_slot    <= '0;
      r_rom_dir <= '0;
      r_rom_y   <= '0;
      r_rom_x   <= '0;
      for (int s = 0; s < NUM_SPRITES; s++)
        r_buf[s] <= '0;
    end else if (i_line_start) begin
      r_state <= ST_SCAN;
      r_tgt   <= i_vpos + 9'd1;
      r_slot  <= '0;
    end else begin
      case (r_state)
        ST_SCAN: begin
          if (w_hit) begin
            r_state   <= ST_FETCH;
            r_rom_dir <= w_slot_dir;
            r_rom_y   <= w_off[ROW_W-1:0];
            r_rom_x   <= '0;
          end else begin
            r_buf[r_slot] <= '0;
            if (w_last) begin
              r_state <= ST_IDLE;
            end else begin
              r_slot <= r_slot + IDW'(1);
            end
          end
        end
        ST_FETCH: begin
          r_buf[r_slot][r_rom_x] <= i_rom_bit;
          if (w_col_last) begin
            if (w_last) begin
              r_state <= ST_IDLE;
            end else begin
              r_slot  <= r_slot + IDW'(1);
              r_state <= ST_SCAN;
            end
          end else begin
            r_rom_x <= r_rom_x + COL_W'(1);
          end
        end
        ST_IDLE: ;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  function automatic logic px_on(
    input logic [SPR_W-1:0] row,
    input logic [8:0]       d
  );
    px_on = 1'b0;
    if (d < 9'(SPR_W))
      px_on = row[d[COL_W-1:0]];
  endfunction

  always_comb begin
    for (int s = 0; s < NUM_SPRITES; s++)
      w_d[s] = i_hpos - i_spr_x[s*9 +: 9];
  end

  // Walk from the highest slot down so slot 0 wins overlaps.
  always_comb begin
    w_pix    = 1'b0;
    w_pix_id = '0;
    if (!o_busy) begin
      for (int s = NUM_SPRITES - 1; s >= 0; s--) begin
        if (px_on(r_buf[s], w_d[s])) begin
          w_pix    = 1'b1;
          w_pix_id = IDW'(s);
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pix    <= 1'b0;
      r_pix_id <= '0;
    end else begin
      r_pix    <= w_pix;
      r_pix_id <= w_pix_id;
    end
  end

  assign o_pix     = r_pix;
  assign o_pix_id  = r_pix_id;
  assign o_rom_dir = r_rom_dir;
  assign o_rom_y   = r_rom_y;
  assign o_rom_x   = r_rom_x;

`ifdef SPRITE_ROW_SCHED_ANIM_EN
  logic w_anim;

  sprite_anim_timer #(
    .ANIM_FRAMES(ANIM_FRAMES)
  ) u_anim (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_frame_start(i_frame_start),
    .o_anim       (w_anim)
  );

  assign o_rom_anim = w_anim;
`else
  logic w_unused;

  assign w_unused   = i_frame_start ^ (ANIM_FRAMES == 0);
  assign o_rom_anim = 1'b0;
`endif
endmodule

// File: tb/tb_sprite_row_scheduler.sv
// Scoreboard bench for sprite_row_scheduler: stimulus queues expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_sprite_row_scheduler;
  localparam int NS = 4;
`ifdef SPRITE_ROW_SCHED_ANIM_EN
  localparam logic [8:0] ANIM_AFTER8 = 9'd1;
`else
  localparam logic [8:0] ANIM_AFTER8 = 9'd0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            ls = 1'b0;
  logic            fs = 1'b0;
  logic [8:0]      hpos = '0;
  logic [8:0]      vpos = '0;
  logic [NS-1:0]   en = '0;
  logic [8:0]      sx [NS];
  logic [8:0]      sy [NS];
  logic [1:0]      sd [NS];
  logic [8:0]      eb [NS];
  logic [NS*9-1:0] spr_x;
  logic [NS*9-1:0] spr_y;
  logic [NS*2-1:0] spr_dir;
  logic [1:0]      rom_dir;
  logic            rom_anim;
  logic [3:0]      rom_y;
  logic [3:0]      rom_x;
  logic            rom_bit;
  logic            pix;
  logic [1:0]      pix_id;
  logic            busy;
  logic [8:0]      w_row;

  int         checks = 0;
  int         failures = 0;
  int         q_sel [$];
  logic [8:0] q_v [$];
  string      q_nm [$];

  always #5 clk = ~clk;

  always_comb begin
    spr_x = '0;
    spr_y = '0;
    spr_dir = '0;
    for (int i = 0; i < NS; i++) begin
      spr_x[i*9 +: 9] = sx[i];
      spr_y[i*9 +: 9] = sy[i];
      spr_dir[i*2 +: 2] = sd[i];
    end
  end

  function automatic logic [8:0] rom_row(
    input logic [1:0] d, input logic a, input logic [3:0] y);
    if (y == 4'd3) return 9'b110111011;
    return {y, d, a, 2'b01};
  endfunction

  assign w_row = rom_row(rom_dir, rom_anim, rom_y);
  assign rom_bit = (rom_x < 4'd9) ? w_row[rom_x] : 1'b0;

  sprite_row_scheduler dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_line_start (ls),
    .i_frame_start(fs),
    .i_hpos       (hpos),
    .i_vpos       (vpos),
    .i_spr_en     (en),
    .i_spr_x      (spr_x),
    .i_spr_y      (spr_y),
    .i_spr_dir    (spr_dir),
    .o_rom_dir    (rom_dir),
    .o_rom_anim   (rom_anim),
    .o_rom_y      (rom_y),
    .o_rom_x      (rom_x),
    .i_rom_bit    (rom_bit),
    .o_pix        (pix),
    .o_pix_id     (pix_id),
    .o_busy       (busy)
  );

  function automatic logic [8:0] observe(input int sel);
    case (sel)
      0: return {6'd0, pix, pix_id};
      1: return {8'd0, busy};
      2: return {5'd0, rom_y};
      3: return {5'd0, rom_x};
      4: return {7'd0, rom_dir};
      5: return {8'd0, rom_anim};
      default: return 9'h1ff;
    endcase
  endfunction

  always @(negedge clk) begin
    int sel;
    logic [8:0] v;
    logic [8:0] a;
    string nm;
    while (q_sel.size() > 0) begin
      sel = q_sel.pop_front();
      v = q_v.pop_front();
      nm = q_nm.pop_front();
      a = observe(sel);
      checks++;
      if (a !== v) begin
        failures++;
        $display("FAIL %s: got %0d, expected %0d", nm, a, v);
      end
    end
  end

  task automatic expect_(input int sel, input logic [8:0] v, input string nm);
    q_sel.push_back(sel);
    q_v.push_back(v);
    q_nm.push_back(nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_line(input logic [8:0] v);
    vpos = v;
    ls = 1'b1;
    tick();
    ls = 1'b0;
  endtask

  function automatic logic [8:0] exp_pix(input logic [8:0] h);
    logic [8:0] d;
    logic [8:0] r;
    logic p;
    logic [1:0] id;
    p = 1'b0;
    id = 2'd0;
    for (int s = NS - 1; s >= 0; s--) begin
      d = h - sx[s];
      r = eb[s];
      if (d < 9'd9 && r[d[3:0]]) begin
        p = 1'b1;
        id = 2'(s);
      end
    end
    return {6'd0, p, id};
  endfunction

  task automatic sweep(input int lo, input int hi, input string tag);
    for (int h = lo; h <= hi; h++) begin
      hpos = 9'(h);
      tick();
      expect_(0, exp_pix(9'(h)), $sformatf("%s pix h=%0d", tag, h));
    end
  endtask

  initial begin
    for (int i = 0; i < NS; i++) begin
      sx[i] = '0;
      sy[i] = '0;
      sd[i] = '0;
      eb[i] = '0;
    end
    tick();
    tick();
    expect_(1, 9'd0, "reset busy");
    expect_(0, 9'd0, "reset pix");
    expect_(2, 9'd0, "reset rom_y");
    expect_(3, 9'd0, "reset rom_x");
    expect_(4, 9'd0, "reset rom_dir");
    expect_(5, 9'd0, "reset rom_anim");
    tick();
    rst = 1'b0;
    tick();

    // A: single sprite, row 3 fetched on line 52 for line 53
    en = 4'b0001;
    sx[0] = 9'd100; sy[0] = 9'd50; sd[0] = 2'd2;
    pulse_line(9'd52);
    for (int i = 0; i < 13; i++) begin
      expect_(1, 9'd1, $sformatf("A busy i=%0d", i));
      if (i >= 1 && i <= 9) begin
        expect_(2, 9'd3, "A rom_y");
        expect_(3, 9'(i - 1), $sformatf("A rom_x i=%0d", i));
        expect_(4, 9'd2, "A rom_dir");
      end
      tick();
    end
    expect_(1, 9'd0, "A busy end");
    eb[0] = 9'b110111011;
    sweep(98, 110, "A");

    // B: all slots enabled, none in range
    en = 4'b1111;
    for (int i = 0; i < NS; i++) begin
      sy[i] = 9'd200;
      sx[i] = 9'd100;
    end
    pulse_line(9'd52);
    for (int i = 0; i < 4; i++) begin
      expect_(1, 9'd1, $sformatf("B busy i=%0d", i));
      expect_(2, 9'd3, "B rom_y hold");
      expect_(3, 9'd8, "B rom_x hold");
      tick();
    end
    expect_(1, 9'd0, "B busy end");
    eb[0] = '0;
    sweep(98, 110, "B");

    // C: slots 0 and 2 overlap, slot 0 has priority
    en = 4'b0101;
    sx[0] = 9'd200; sy[0] = 9'd100; sd[0] = 2'd1;
    sx[2] = 9'd200; sy[2] = 9'd100; sd[2] = 2'd3;
    pulse_line(9'd104);
    for (int i = 0; i < 22; i++) begin
      expect_(1, 9'd1, $sformatf("C busy i=%0d", i));
      if (i >= 1 && i <= 9) begin
        expect_(4, 9'd1, "C rom_dir s0");
        expect_(2, 9'd5, "C rom_y s0");
        expect_(3, 9'(i - 1), $sformatf("C rom_x s0 i=%0d", i));
      end
      if (i >= 12 && i <= 20) begin
        expect_(4, 9'd3, "C rom_dir s2");
        expect_(3, 9'(i - 12), $sformatf("C rom_x s2 i=%0d", i));
      end
      tick();
    end
    expect_(1, 9'd0, "C busy end");
    eb[0] = 9'b010101001;
    eb[2] = 9'b010111001;
    sweep(198, 210, "C");

    // D: vertical wrap (y=510, tgt=3) plus abort/restart mid-fetch
    en = 4'b0001;
    sx[0] = 9'd300; sy[0] = 9'd510; sd[0] = 2'd0;
    pulse_line(9'd2);
    expect_(1, 9'd1, "D busy scan");
    tick();
    expect_(2, 9'd5, "D rom_y first");
    expect_(3, 9'd0, "D rom_x first");
    tick();
    expect_(3, 9'd1, "D rom_x second");
    pulse_line(9'd2);
    expect_(1, 9'd1, "D busy restart");
    expect_(3, 9'd1, "D rom_x hold on abort");
    tick();
    for (int i = 1; i < 13; i++) begin
      expect_(1, 9'd1, $sformatf("D busy i=%0d", i));
      if (i <= 9) begin
        expect_(2, 9'd5, "D rom_y");
        expect_(3, 9'(i - 1), $sformatf("D rom_x i=%0d", i));
      end
      tick();
    end
    expect_(1, 9'd0, "D busy end");
    eb[0] = 9'b010100001;
    eb[2] = '0;
    sweep(298, 310, "D");

    // Animation phase
    for (int k = 0; k < 8; k++) begin
      fs = 1'b1;
      tick();
      fs = 1'b0;
      tick();
    end
    expect_(5, ANIM_AFTER8, "anim after 8");
    for (int k = 0; k < 8; k++) begin
      fs = 1'b1;
      tick();
      fs = 1'b0;
      tick();
    end
    expect_(5, 9'd0, "anim after 16");
    tick();

    // Reset mid-fetch at slot 1, column 4
    en = 4'b0011;
    sx[0] = 9'd100; sy[0] = 9'd50; sd[0] = 2'd2;
    sx[1] = 9'd120; sy[1] = 9'd52; sd[1] = 2'd1;
    pulse_line(9'd52);
    for (int i = 0; i < 15; i++) begin
      expect_(1, 9'd1, $sformatf("R busy i=%0d", i));
      tick();
    end
    expect_(3, 9'd4, "R rom_x pre");
    expect_(2, 9'd1, "R rom_y pre");
    expect_(4, 9'd1, "R rom_dir pre");
    @(negedge clk);
    #1;
    rst = 1'b1;
    tick();
    expect_(1, 9'd0, "R busy");
    expect_(0, 9'd0, "R pix");
    expect_(3, 9'd0, "R rom_x");
    expect_(2, 9'd0, "R rom_y");
    expect_(5, 9'd0, "R rom_anim");
    rst = 1'b0;
    eb[0] = '0;
    sweep(98, 130, "R");

    tick();
    tick();
    checks++;
    if (q_sel.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending, expected 0", q_sel.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
